fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer. It requests the word at pc_cur from
//   instruction memory, holds the returned word for the downstream stage until
//   it is accepted, and then loads the program counter with the sequential
//   address. A branch redirect loads the PC with the branch target instead.
//
//   Optional feature: define macro FETCH_TIMEOUT_EN to add a REQ watchdog.
//   After TIMEOUT consecutive REQ cycles without mem_ack the block parks in a
//   FAULT state with fetch_err=1 until reset. Without the macro, fetch_err is
//   tied to 0 and REQ waits forever.
//
// Parameters
//   PC_STEP        sequential PC increment in bytes
//   TIMEOUT        REQ cycles without mem_ack before FAULT (FETCH_TIMEOUT_EN only)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   pc_cur         current PC from the program counter register
//   next_pc        registered PC load value (bits [1:0] always 0)
//   update_pc      PC load enable, one cycle in UPDATE
//   mem_req        instruction memory read request
//   mem_addr       read address (pc_cur while mem_req=1, else 0)
//   mem_ack        read data valid, honoured only in REQ
//   mem_rdata      instruction word from memory
//   instr          registered fetched instruction
//   instr_valid    instr valid for the downstream stage
//   instr_ready    downstream accepts instr
//   branch_taken   redirect request qualifier
//   branch_target  redirect address
//   fetch_err      sticky timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] next_pc,
  output logic        update_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, VALID, UPDATE, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, VALID, UPDATE} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] next_pc_nxt;
  logic [31:0] instr_nxt;

  // PC values loaded into the program counter are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  // The counter sits at 0 outside REQ, so it is implicitly cleared on every
  // entry into REQ. timed_out flags the TIMEOUT-th ack-less REQ cycle.
  always_ff @(posedge clk) begin
    if (reset || state != REQ) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      next_pc <= '0;
      instr   <= '0;
    end else begin
      state   <= state_nxt;
      next_pc <= next_pc_nxt;
      instr   <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    next_pc_nxt = next_pc;
    instr_nxt   = instr;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    update_pc   = 1'b0;
    fetch_err   = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = REQ;
      end

      REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_cur;
        // A redirect wins over a same-cycle ack; the returned word is dropped.
        if (branch_taken) begin
          next_pc_nxt = word_align(branch_target);
          state_nxt   = UPDATE;
        end else if (mem_ack) begin
          instr_nxt = mem_rdata;
          state_nxt = VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timed_out) begin
          state_nxt = FAULT;
        end
`endif
      end

      VALID: begin
        instr_valid = 1'b1;
        if (branch_taken) begin
          next_pc_nxt = word_align(branch_target);
          state_nxt   = UPDATE;
        end else if (instr_ready) begin
          next_pc_nxt = word_align(pc_cur + 32'(PC_STEP));
          state_nxt   = UPDATE;
        end
      end

      UPDATE: begin
        update_pc = 1'b1;
        // A redirect arriving while the PC loads replaces the load value and
        // keeps the load enable up for one more cycle.
        if (branch_taken) begin
          next_pc_nxt = word_align(branch_target);
          state_nxt   = UPDATE;
        end else begin
          state_nxt = REQ;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      FAULT: begin
        fetch_err = 1'b1;
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
